// File: rtl/number_slot_sequencer.sv
// Captures a packed bank of SLOTS numbers on start and presents them one at a
// time over valid/ready, optionally skipping zero-valued slots.
module number_slot_sequencer #(
    parameter int unsigned SLOTS     = 10,
    parameter int unsigned WIDTH     = 20,
    parameter bit          SKIP_ZERO = 1'b1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [SLOTS*WIDTH-1:0] number,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_number,
    output logic [3:0]             out_index,
    output logic [3:0]             out_count,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned BANK_W = SLOTS * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BANK_W-1:0]  r_bank;
    logic [BANK_W-1:0]  w_bank_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [WIDTH-1:0]   r_number;
    logic [WIDTH-1:0]   w_number_nxt;
    logic [IDX_W-1:0]   r_index;
    logic [IDX_W-1:0]   w_index_nxt;
    logic [IDX_W-1:0]   r_count;
    logic [IDX_W-1:0]   w_count_nxt;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_slots [SLOTS];
    logic [WIDTH-1:0]   w_slot;
    logic               w_last;

    // Unpack the captured bank so the current slot is a simple array read.
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        assign w_slots[g] = r_bank[g*WIDTH +: WIDTH];
    end

    assign w_slot = w_slots[r_idx];
    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_bank   <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_number <= '0;
            r_index  <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bank   <= w_bank_nxt;
            r_idx    <= w_idx_nxt;
            r_valid  <= w_valid_nxt;
            r_number <= w_number_nxt;
            r_index  <= w_index_nxt;
            r_count  <= w_count_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_FINISH);
        end
    end

    // Abort takes priority over every transition, including a pending handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_bank_nxt   = r_bank;
        w_idx_nxt    = r_idx;
        w_valid_nxt  = r_valid;
        w_number_nxt = r_number;
        w_index_nxt  = r_index;
        w_count_nxt  = r_count;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_bank_nxt  = number;
                    w_idx_nxt   = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (SKIP_ZERO && (w_slot == '0)) begin
                    if (w_last) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_number_nxt = w_slot;
                    w_index_nxt  = r_idx;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (abort) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (out_ready) begin
                    w_count_nxt = r_count + IDX_W'(1);
                    w_valid_nxt = 1'b0;
                    if (w_last) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = S_SCAN;
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign out_valid  = r_valid;
    assign out_number = r_number;
    assign out_index  = r_index;
    assign out_count  = r_count;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
